// File: rtl/rom_fetch.sv
// Instruction-fetch initiator: drives ROM addresses, buffers words in a prefetch FIFO,
// and hands them to the decoder. Optional FETCH_PERF_EN adds fetch/stall counters.
module rom_fetch #(
    parameter logic [31:0] ROM_BASE_ADDR = 32'h0000_1000,
    parameter logic [31:0] ROM_END_ADDR  = 32'h0000_1100,
    parameter logic [31:0] RESET_PC      = ROM_BASE_ADDR,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] bus_addr,
    input  logic [31:0] bus_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        inst_fault
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {FETCH, HALT} state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        fault;
    } entry_t;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    entry_t          mem_q [FIFO_DEPTH];
    entry_t          push_entry, head;
    logic            push, pop, pop_eff, can_push, is_fault;

    assign bus_addr   = pc_q;
    assign inst_valid = (count_q != '0);
    assign pop        = inst_valid & inst_ready;
    assign can_push   = (count_q < CW'(FIFO_DEPTH)) | pop;
    assign is_fault   = (pc_q < ROM_BASE_ADDR) || (pc_q >= ROM_END_ADDR) || (pc_q[1:0] != 2'b00);

    // Empty FIFO presents zeros so stale entries never leak onto the decoder port.
    assign head       = mem_q[rd_ptr_q];
    assign inst_data  = inst_valid ? head.data  : 32'h0;
    assign inst_pc    = inst_valid ? head.pc    : 32'h0;
    assign inst_fault = inst_valid ? head.fault : 1'b0;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        push       = 1'b0;
        pop_eff    = pop;
        push_entry = '{data: bus_data, pc: pc_q, fault: 1'b0};
        if (redirect_valid) begin
            pop_eff = 1'b0;
            pc_d    = redirect_pc;
            state_d = FETCH;
        end else if (state_q == FETCH && can_push) begin
            push = 1'b1;
            if (is_fault) begin
                // Bus data is undefined outside the window; never capture it.
                push_entry = '{data: 32'h0, pc: pc_q, fault: 1'b1};
                state_d    = HALT;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    always_comb begin
        count_d  = count_q + CW'(push) - CW'(pop_eff);
        wr_ptr_d = push    ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_eff ? rd_ptr_q + PW'(1) : rd_ptr_q;
        if (redirect_valid) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (push && !push_entry.fault) perf_fetch_q <= perf_fetch_q + 32'd1;
            if (!redirect_valid && state_q == FETCH && !can_push) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_rom_fetch.sv
// Self-checking bench for rom_fetch: directed steps plus random traffic against a queue model.
module tb_rom_fetch;

    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam logic [31:0] END_A  = 32'h0000_1100;
    localparam logic [31:0] RST_PC = BASE;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] bus_addr, bus_data, redirect_pc, inst_data, inst_pc;
    logic        redirect_valid, inst_valid, inst_ready, inst_fault;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    rom_fetch #(
        .ROM_BASE_ADDR(BASE), .ROM_END_ADDR(END_A), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_data(bus_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .inst_pc(inst_pc), .inst_fault(inst_fault)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] rom [64];

    function automatic logic in_window(input logic [31:0] a);
        return (a >= BASE) && (a < END_A) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] rom_rd(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) >> 2;
        if (in_window(a)) return rom[off[5:0]];
        return 32'hDEAD_BEEF;
    endfunction

    always_comb bus_data = rom_rd(bus_addr);

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
        logic        fault;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    logic        m_halt;
    int          m_fetch, m_stall;
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic check_all();
        ent_t h;
        h = '{data: 32'h0, pc: 32'h0, fault: 1'b0};
        if (q.size() != 0) h = q[0];
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, q.size() != 0});
        chk("bus_addr",   bus_addr, m_pc);
        chk("inst_data",  inst_data, h.data);
        chk("inst_pc",    inst_pc, h.pc);
        chk("inst_fault", {31'b0, inst_fault}, {31'b0, h.fault});
`ifdef FETCH_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, m_fetch);
        chk("perf_stall", perf_stall_cnt, m_stall);
`endif
    endtask

    task automatic model_reset();
        q.delete();
        m_pc    = RST_PC;
        m_halt  = 1'b0;
        m_fetch = 0;
        m_stall = 0;
    endtask

    // Apply inputs for one cycle, advance the model, then compare after the edge.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        ent_t tmp;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (rv) begin
            q.delete();
            m_pc   = rpc;
            m_halt = 1'b0;
        end else begin
            if (rdy && q.size() != 0) tmp = q.pop_front();
            if (!m_halt) begin
                if (q.size() < DEPTH) begin
                    if (!in_window(m_pc)) begin
                        q.push_back('{data: 32'h0, pc: m_pc, fault: 1'b1});
                        m_halt = 1'b1;
                    end else begin
                        q.push_back('{data: rom_rd(m_pc), pc: m_pc, fault: 1'b0});
                        m_pc = m_pc + 32'd4;
                        m_fetch++;
                    end
                end else begin
                    m_stall++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(rdy, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] rpc;
        logic        rv;
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33;
        rst_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        check_all();

        // Streaming, then backpressure fill/drain
        run(3, 1'b1);
        run(6, 1'b0);
        run(8, 1'b1);

        // Redirect with entries buffered
        run(3, 1'b0);
        step(1'b1, 1'b1, BASE + 32'h40);
        run(3, 1'b1);

        // Run off the end of the window, then sit halted
        step(1'b1, 1'b1, END_A - 32'h10);
        run(8, 1'b1);
        run(3, 1'b0);
        run(3, 1'b1);

        // Misaligned, below-window and top-of-space redirects
        step(1'b0, 1'b1, BASE + 32'h2);
        run(3, 1'b0);
        run(2, 1'b1);
        step(1'b1, 1'b1, BASE - 32'h4);
        run(3, 1'b1);
        step(1'b1, 1'b1, 32'hFFFF_FFFC);
        run(3, 1'b1);

        // Asynchronous reset with two entries buffered
        step(1'b0, 1'b1, BASE + 32'h20);
        run(2, 1'b0);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        check_all();

        // Five fetches then three full-FIFO stalls
        run(2, 1'b1);
        run(6, 1'b0);
        run(5, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       rpc = BASE + 32'(4 * $urandom_range(0, 63));
                1:       rpc = END_A - 32'(4 * $urandom_range(1, 4));
                2:       rpc = BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
                default: rpc = $urandom;
            endcase
            step(1'($urandom_range(0, 1)), rv, rpc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
